// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the buffered UART transmit front-end.
//   - DEFAULT_PAYLOAD_BITS : default word width shared with uart_tx
//   - tx_state_t           : launch FSM state encoding (2 bits)
package uart_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRIG   = 2'd1,
        WAIT_B = 2'd2,
        WAIT_I = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Handshake bundle around uart_tx_fifo.
//   Producer side : i_wr_valid, i_wr_data -> ; <- o_wr_ready
//   uart_tx side  : <- o_tx_trig, o_tx_data ; i_tx_busy ->
//   master : the environment (producer + uart_tx)
//   slave  : uart_tx_fifo
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS
) ();

    logic                    i_wr_valid;
    logic [PAYLOAD_BITS-1:0] i_wr_data;
    logic                    o_wr_ready;
    logic                    o_tx_trig;
    logic [PAYLOAD_BITS-1:0] o_tx_data;
    logic                    i_tx_busy;

    modport master (
        output i_wr_valid,
        output i_wr_data,
        output i_tx_busy,
        input  o_wr_ready,
        input  o_tx_trig,
        input  o_tx_data
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_data,
        input  i_tx_busy,
        output o_wr_ready,
        output o_tx_trig,
        output o_tx_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Generic single-clock FIFO with first-word-fall-through head output.
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     push, push_data : write request; ignored while full
//     pop             : read request; ignored while empty
//     head_data       : oldest stored word, valid whenever !empty
//     level           : registered occupancy, 0..FIFO_DEPTH
//     empty, full     : occupancy flags from the pointer comparison
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int  PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int  FIFO_DEPTH   = 16,
    localparam int AW           = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [PAYLOAD_BITS-1:0] push_data,
    input  logic                    pop,
    output logic [PAYLOAD_BITS-1:0] head_data,
    output logic [AW:0]             level,
    output logic                    empty,
    output logic                    full
);

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic                    push_ok;
    logic                    pop_ok;

    // Pointers carry one extra MSB: equal low bits with differing MSB means
    // the writer has lapped the reader once, i.e. full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered transmit front-end for uart_tx (same clock domain). Queues
//   producer words and launches them one at a time with a single-cycle
//   trigger, waiting for uart_tx to finish each frame.
//   Ports:
//     clk, reset_n  : clock, async active-low reset
//     bus (slave)   : producer valid/ready + uart_tx trig/data/busy
//     i_clr_sticky  : clears o_overflow and o_tx_err (wins over a set)
//     o_level       : FIFO occupancy, 0..FIFO_DEPTH
//     o_empty/o_full: occupancy flags
//     o_overflow    : sticky, a word was offered while full
//     o_tx_err      : sticky, uart_tx never raised busy after a trigger
//
//   state  | meaning
//   IDLE   | waiting for a queued word and uart_tx not busy; pops on launch
//   TRIG   | o_tx_trig high for this one cycle; timeout counter cleared
//   WAIT_B | waiting for busy to rise; gives up after BUSY_TIMEOUT cycles
//   WAIT_I | frame in progress; waiting for busy to fall
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int  FIFO_DEPTH   = 16,
    parameter int  BUSY_TIMEOUT = 64,
    localparam int LEVEL_BITS   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_fifo_if.slave         bus,
    input  logic                  i_clr_sticky,
    output logic [LEVEL_BITS-1:0] o_level,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic                  o_tx_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

    tx_state_t               state;
    logic [CW-1:0]           to_cnt;
    logic [PAYLOAD_BITS-1:0] head_data;
    logic                    fifo_pop;
    logic                    timeout_hit;
    logic                    overflow_hit;
    logic                    tx_trig;
    logic [PAYLOAD_BITS-1:0] tx_data;

    uart_sync_fifo #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.i_wr_valid),
        .push_data (bus.i_wr_data),
        .pop       (fifo_pop),
        .head_data (head_data),
        .level     (o_level),
        .empty     (o_empty),
        .full      (o_full)
    );

    assign bus.o_wr_ready = !o_full;
    assign bus.o_tx_trig  = tx_trig;
    assign bus.o_tx_data  = tx_data;

    assign fifo_pop     = (state == IDLE) && !o_empty && !bus.i_tx_busy;
    assign timeout_hit  = (state == WAIT_B) && !bus.i_tx_busy
                          && (to_cnt == CW'(BUSY_TIMEOUT - 1));
    // The FIFO refuses the word because ready is already low, even if a pop
    // happens in the same cycle.
    assign overflow_hit = bus.i_wr_valid && o_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx_trig <= 1'b0;
            tx_data <= '0;
            to_cnt  <= '0;
        end else begin
            tx_trig <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        tx_data <= head_data;
                        tx_trig <= 1'b1;
                        state   <= TRIG;
                    end
                end
                TRIG: begin
                    to_cnt <= '0;
                    state  <= WAIT_B;
                end
                WAIT_B: begin
                    if (bus.i_tx_busy) begin
                        state <= WAIT_I;
                    end else if (timeout_hit) begin
                        // uart_tx never accepted the word; drop it and move on.
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                WAIT_I: begin
                    if (!bus.i_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_overflow <= 1'b0;
            o_tx_err   <= 1'b0;
        end else if (i_clr_sticky) begin
            o_overflow <= 1'b0;
            o_tx_err   <= 1'b0;
        end else begin
            if (overflow_hit) begin
                o_overflow <= 1'b1;
            end
            if (timeout_hit) begin
                o_tx_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A small uart_tx stand-in raises busy the
//   cycle after a trigger and holds it for FRAME cycles; a monitor logs every
//   launched word and the busy-fall to trigger gap.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int PB    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 64;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_sticky;
    logic [LW-1:0] level;
    logic          empty, full, overflow, tx_err;

    // 0: busy driven by busy_force; 1: stand-in answers triggers; 2: stand-in never answers
    int   stub_mode;
    logic busy_force;
    logic stub_busy;
    int   stub_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [PB-1:0] tx_log [$];
    int            gap_q [$];
    int            cyc = 0;
    int            fall_cyc = -1;
    logic          prev_busy = 1'b0;

    always #50 clk = ~clk;

    uart_tx_fifo_if #(.PAYLOAD_BITS(PB)) bus ();

    assign bus.i_tx_busy = (stub_mode == 0) ? busy_force : stub_busy;

    uart_tx_fifo #(
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (DEPTH),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .i_clr_sticky (clr_sticky),
        .o_level      (level),
        .o_empty      (empty),
        .o_full       (full),
        .o_overflow   (overflow),
        .o_tx_err     (tx_err)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (stub_mode == 1 && bus.o_tx_trig) begin
            stub_busy <= 1'b1;
            stub_cnt  <= FRAME;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else begin
            stub_cnt  <= 0;
            stub_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.o_tx_trig) begin
            tx_log.push_back(bus.o_tx_data);
            if (fall_cyc >= 0) gap_q.push_back(cyc - fall_cyc);
            fall_cyc = -1;
        end
        if (prev_busy && !bus.i_tx_busy) fall_cyc = cyc;
        prev_busy = bus.i_tx_busy;
    end

    typedef struct {
        logic          valid;
        logic [PB-1:0] data;
        logic          busy;
        logic [LW-1:0] lvl;
        logic          trig;
        logic [PB-1:0] txd;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PB-1:0] d);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = d;
        step();
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (tx_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ready"}, 32'(bus.o_wr_ready), 32'd1);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_err"}, 32'(tx_err), 32'd0);
        chk({tag, "_trig"}, 32'(bus.o_tx_trig), 32'd0);
        chk({tag, "_data"}, 32'(bus.o_tx_data), 32'd0);
    endtask

    initial begin
        int base;
        int n;

        //          valid  data    busy  lvl trig txd
        tbl[0]  = '{1'b1, 8'hAB, 1'b0, 1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 8'hAB};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'hAB};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hAB};
        tbl[4]  = '{1'b1, 8'hCD, 1'b1, 1, 1'b0, 8'hAB};
        tbl[5]  = '{1'b1, 8'hEF, 1'b0, 2, 1'b0, 8'hAB};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hCD};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'hCD};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hCD};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'hCD};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hCD};
        tbl[11] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'hEF};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hEF};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hEF};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'hEF};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h11};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h11};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h11};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h11};

        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        clr_sticky     = 1'b0;
        busy_force     = 1'b0;
        stub_mode      = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // Cycle-exact single word, push+pop at level 1, busy holding IDLE
        for (int i = 0; i < 19; i++) begin
            bus.i_wr_valid = tbl[i].valid;
            bus.i_wr_data  = tbl[i].data;
            busy_force     = tbl[i].busy;
            step();
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].lvl == 0));
            chk($sformatf("vec%0d_trig", i), 32'(bus.o_tx_trig), 32'(tbl[i].trig));
            chk($sformatf("vec%0d_txdata", i), 32'(bus.o_tx_data), 32'(tbl[i].txd));
        end
        bus.i_wr_valid = 1'b0;
        busy_force     = 1'b0;

        // Burst through the uart_tx stand-in
        stub_mode = 1;
        step();
        base = tx_log.size();
        push(8'hAB);
        push(8'hCD);
        chk("burst_first_trig", 32'(bus.o_tx_trig), 32'd1);
        chk("burst_first_data", 32'(bus.o_tx_data), 32'hAB);
        push(8'hEF);
        chk("burst_peak_level", 32'(level >= 2 && level <= 3), 32'd1);
        wait_log(base + 3, 300, "burst_frames_bound");
        chk("burst_word0", 32'(tx_log[base]), 32'hAB);
        chk("burst_word1", 32'(tx_log[base + 1]), 32'hCD);
        chk("burst_word2", 32'(tx_log[base + 2]), 32'hEF);
        chk("burst_gap_cd", 32'(gap_q[gap_q.size() - 2]), 32'd2);
        chk("burst_gap_ef", 32'(gap_q[gap_q.size() - 1]), 32'd2);
        repeat (FRAME + 5) step();
        chk("burst_level_end", 32'(level), 32'd0);

        // Overflow with uart_tx held busy
        stub_mode  = 0;
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(i + 1));
            chk($sformatf("ovf_fill%0d", i), 32'(level), 32'(i + 1));
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        push(8'hF0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level16", 32'(level), 32'd16);
        // clear beats a same-cycle overflow
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'hF1;
        clr_sticky     = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("ovf_clr_priority", 32'(overflow), 32'd0);
        // release busy while still offering a word: the pop does not rescue it
        base           = tx_log.size();
        stub_mode      = 1;
        bus.i_wr_data  = 8'h99;
        step();
        bus.i_wr_valid = 1'b0;
        chk("ovf_pop_no_rescue", 32'(overflow), 32'd1);
        chk("ovf_level15", 32'(level), 32'd15);
        wait_log(base + 16, 700, "ovf_frames_bound");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_word%0d", i), 32'(tx_log[base + i]), 32'(i + 1));
        end
        repeat (FRAME + 5) step();
        chk("ovf_no_extra", 32'(tx_log.size()), 32'(base + 16));
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Busy never rises after a trigger
        stub_mode = 2;
        push(8'hA1);
        push(8'hA2);
        chk("to_trig", 32'(bus.o_tx_trig), 32'd1);
        chk("to_data", 32'(bus.o_tx_data), 32'hA1);
        n = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            n++;
            if (tx_err) break;
        end
        chk("to_cycles", 32'(n), 32'd65);
        step();
        chk("to_next_trig", 32'(bus.o_tx_trig), 32'd1);
        chk("to_next_data", 32'(bus.o_tx_data), 32'hA2);
        repeat (70) step();
        chk("to_err_sticky", 32'(tx_err), 32'd1);

        // Reset while a frame is in flight with 5 queued
        stub_mode = 1;
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        chk("rst_pre_level", 32'(level), 32'd5);
        chk("rst_pre_busy", 32'(bus.i_tx_busy), 32'd1);
        #20;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base = tx_log.size();
        repeat (40) step();
        chk("rst_no_trig", 32'(tx_log.size()), 32'(base));
        chk("rst_level", 32'(level), 32'd0);
        push(8'h77);
        step();
        chk("rst_new_trig", 32'(bus.o_tx_trig), 32'd1);
        chk("rst_new_data", 32'(bus.o_tx_data), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
